// File: rtl/manchester_nrz_decoder.sv
// Oversampled Manchester-to-NRZ decoder: timing recovery, lock/err, word deserialiser.
// Define MAN_ERR_CNT_EN to add the saturating 16-bit err_cnt output.
module manchester_nrz_decoder #(
  parameter int OSR      = 8,
  parameter int WORD_W   = 8,
  parameter bit POLARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              man,
  output logic              nrz_bit,
  output logic              nrz_valid,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              locked,
  output logic              err
`ifdef MAN_ERR_CNT_EN
  ,
  output logic [15:0]       err_cnt
`endif
);

  localparam int SAT = 2 * OSR;
  localparam int CW  = $clog2(SAT + 1);
  localparam int BW  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [CW-1:0] LO_C   = CW'(3 * OSR / 4);
  localparam logic [CW-1:0] HI_C   = CW'(5 * OSR / 4);
  localparam logic [CW-1:0] SAT_C  = CW'(SAT);
  localparam logic [BW-1:0] LAST_C = BW'(WORD_W - 1);

  if (OSR < 4 || (OSR % 2) != 0) begin : g_bad_osr
    $error("OSR must be even and >= 4");
  end

  if (WORD_W < 1 || WORD_W > 32) begin : g_bad_word
    $error("WORD_W must be 1..32");
  end

  typedef enum logic {
    HUNT,
    LOCK
  } state_t;

  state_t            state;
  logic              s1;
  logic              s2;
  logic              s3;
  logic [CW-1:0]     cnt;
  logic              hit;
  logic              hit_bit;
  logic              line_edge;
  logic              in_win;
  logic              mid_ok;
  logic              drop;
  logic [WORD_W-1:0] shift;
  logic [WORD_W-1:0] shift_nx;
  logic [BW-1:0]     bit_cnt;

  assign line_edge = s2 ^ s3;
  assign in_win    = (cnt >= LO_C) && (cnt < HI_C);
  assign mid_ok    = line_edge && in_win;
  // An edge landing on the last in-window count beats the timeout.
  assign drop      = (state == LOCK) && !mid_ok
                     && (cnt == HI_C - 1'b1);
  assign shift_nx  = (shift << 1) | WORD_W'(hit_bit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= man;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HUNT;
      cnt     <= '0;
      locked  <= 1'b0;
      err     <= 1'b0;
      hit     <= 1'b0;
      hit_bit <= 1'b0;
    end else begin
      hit <= 1'b0;
      err <= 1'b0;
      unique case (state)
        HUNT: begin
          if (line_edge) begin
            cnt <= '0;
            if (cnt >= LO_C) begin
              state   <= LOCK;
              locked  <= 1'b1;
              hit     <= 1'b1;
              hit_bit <= s2 ^ POLARITY;
            end
          end else if (cnt != SAT_C) begin
            cnt <= cnt + 1'b1;
          end
        end
        LOCK: begin
          if (mid_ok) begin
            cnt     <= '0;
            hit     <= 1'b1;
            hit_bit <= s2 ^ POLARITY;
          end else if (drop) begin
            cnt    <= cnt + 1'b1;
            state  <= HUNT;
            locked <= 1'b0;
            err    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nrz_bit    <= 1'b0;
      nrz_valid  <= 1'b0;
      word       <= '0;
      word_valid <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
    end else begin
      nrz_valid  <= hit;
      word_valid <= 1'b0;
      if (hit) begin
        nrz_bit <= hit_bit;
        shift   <= shift_nx;
        if (bit_cnt == LAST_C) begin
          bit_cnt    <= '0;
          word       <= shift_nx;
          word_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (err) begin
        bit_cnt <= '0;
      end
    end
  end

`ifdef MAN_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (drop && err_cnt != 16'hFFFF) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_manchester_nrz_decoder.sv
// Directed bench for manchester_nrz_decoder, POLARITY 0 and 1 side by side.
// Covers reset, lock latency, boundary-edge rejection, timeout and jitter.
module tb_manchester_nrz_decoder;

  logic       clk;
  logic       rst;
  logic       man;
  logic       b0, v0, wv0, lk0, e0;
  logic       b1, v1, wv1, lk1, e1;
  logic [7:0] w0, w1;
`ifdef MAN_ERR_CNT_EN
  logic [15:0] ec0, ec1;
`endif

  int errors;
  int checks;

  int          nv   [2];
  int          wv   [2];
  int          ev   [2];
  int          lseen[2];
  logic [31:0] bits [2];
  logic [15:0] wsh  [2];

  manchester_nrz_decoder #(
    .OSR(8), .WORD_W(8), .POLARITY(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst), .man(man),
    .nrz_bit(b0), .nrz_valid(v0),
    .word(w0), .word_valid(wv0),
    .locked(lk0), .err(e0)
`ifdef MAN_ERR_CNT_EN
    , .err_cnt(ec0)
`endif
  );

  manchester_nrz_decoder #(
    .OSR(8), .WORD_W(8), .POLARITY(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .man(man),
    .nrz_bit(b1), .nrz_valid(v1),
    .word(w1), .word_valid(wv1),
    .locked(lk1), .err(e1)
`ifdef MAN_ERR_CNT_EN
    , .err_cnt(ec1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (v0) begin
        nv[0]   <= nv[0] + 1;
        bits[0] <= {bits[0][30:0], b0};
      end
      if (v1) begin
        nv[1]   <= nv[1] + 1;
        bits[1] <= {bits[1][30:0], b1};
      end
      if (wv0) begin
        wv[0]  <= wv[0] + 1;
        wsh[0] <= {wsh[0][7:0], w0};
      end
      if (wv1) begin
        wv[1]  <= wv[1] + 1;
        wsh[1] <= {wsh[1][7:0], w1};
      end
      if (e0) ev[0] <= ev[0] + 1;
      if (e1) ev[1] <= ev[1] + 1;
      if (lk0) lseen[0] <= lseen[0] + 1;
      if (lk1) lseen[1] <= lseen[1] + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear();
    for (int i = 0; i < 2; i++) begin
      nv[i]    = 0;
      wv[i]    = 0;
      ev[i]    = 0;
      lseen[i] = 0;
      bits[i]  = '0;
      wsh[i]   = '0;
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    man = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // 802.3 coding: first half ~b, second half b
  task automatic send(input logic b, input int h1, input int h2);
    hold(~b, h1);
    hold(b, h2);
  endtask

  logic [15:0] data;
  int          h1_tab [16];

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    man    = 1'b0;
    clear();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    hold(1'b0, 20);
    clear();

    // preamble '1','0' inside 0xAA, then 0xA5; first bit timed by hand
    hold(1'b0, 4);
    man = 1'b1;
    @(posedge clk); #1;
    chk("lat_k0_valid", 32'(v0), 32'd0);
    @(posedge clk); #1;
    chk("lat_k1_locked", 32'(lk0), 32'd0);
    @(posedge clk); #1;
    chk("lat_k2_locked", 32'(lk0), 32'd1);
    chk("lat_k2_valid", 32'(v0), 32'd0);
    @(posedge clk); #1;
    chk("lat_k3_valid", 32'(v0), 32'd1);
    chk("lat_k3_bit", 32'(b0), 32'd1);
    data = 16'hAAA5;
    for (int i = 14; i >= 0; i--) send(data[i], 4, 4);
    hold(1'b1, 4);
    chk("t2_nvalid", 32'(nv[0]), 32'd16);
    chk("t2_bits", bits[0][15:0], 32'hAAA5);
    chk("t2_wvalid", 32'(wv[0]), 32'd2);
    chk("t2_words", 32'(wsh[0]), 32'hAAA5);
    chk("t2_word", 32'(w0), 32'hA5);
    chk("t2_err", 32'(ev[0]), 32'd0);
    chk("t5_wvalid", 32'(wv[1]), 32'd2);
    chk("t5_words", 32'(wsh[1]), 32'h555A);
    chk("t5_word", 32'(w1), 32'h5A);

    // reset while locked and holding a word
    rst = 1'b1;
    @(negedge clk);
    chk("t1_outs0", {26'd0, b0, v0, wv0, lk0, e0, |w0}, 32'd0);
    chk("t1_word1", 32'(w1), 32'd0);
    chk("t1_locked1", 32'(lk1), 32'd0);
`ifdef MAN_ERR_CNT_EN
    chk("t1_errcnt", 32'(ec0), 32'd0);
`endif

    // all-ones: only 4-clk intervals until a '0' appears
    man = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear();
    hold(1'b1, 2);
    for (int i = 0; i < 16; i++) send(1'b1, 4, 4);
    chk("t3_nolock_valid", 32'(nv[0]), 32'd0);
    chk("t3_nolock_seen", 32'(lseen[0]), 32'd0);
    send(1'b0, 4, 4);
    for (int i = 0; i < 4; i++) send(1'b1, 4, 4);
    hold(1'b1, 4);
    chk("t3_nvalid", 32'(nv[0]), 32'd5);
    chk("t3_bits", 32'(bits[0][4:0]), 32'h0F);
    chk("t3_locked", 32'(lk0), 32'd1);
    chk("t3_err", 32'(ev[0]), 32'd0);

    // line stuck high: timeout when cnt reaches 10
    hold(1'b1, 4);
    chk("t4_cnt9_err", 32'(e0), 32'd0);
    chk("t4_cnt9_locked", 32'(lk0), 32'd1);
    hold(1'b1, 1);
    chk("t4_cnt10_err", 32'(e0), 32'd1);
    chk("t4_cnt10_locked", 32'(lk0), 32'd0);
    hold(1'b1, 1);
    chk("t4_err_pulse", 32'(e0), 32'd0);
    hold(1'b1, 30);
    chk("t4_err_count", 32'(ev[0]), 32'd1);
    chk("t4_stay_hunt", 32'(lk0), 32'd0);
    chk("t4_word_kept", 32'(w0), 32'd0);
`ifdef MAN_ERR_CNT_EN
    chk("t4_errcnt0", 32'(ec0), 32'd1);
    chk("t4_errcnt1", 32'(ec1), 32'd1);
`endif

    // jittered periods 7/9 plus one 10-clk interval (edge at cnt 9)
    clear();
    data = 16'h3CC3;
    for (int i = 0; i < 16; i++) h1_tab[i] = (i % 2 == 0) ? 5 : 3;
    h1_tab[0]  = 4;
    h1_tab[13] = 6;
    for (int i = 0; i < 16; i++) send(data[15-i], h1_tab[i], 4);
    hold(1'b1, 4);
    chk("t6_nvalid", 32'(nv[0]), 32'd16);
    chk("t6_wvalid", 32'(wv[0]), 32'd2);
    chk("t6_words", 32'(wsh[0]), 32'h3CC3);
    chk("t6_err", 32'(ev[0]), 32'd0);
    chk("t6_locked", 32'(lk0), 32'd1);
    chk("t6_words_pol1", 32'(wsh[1]), 32'hC33C);
    chk("t6_err_pol1", 32'(ev[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
